// File: rtl/memory_cycle_pkg.sv
// Shared encodings and bundles for the RV32I memory stage.
// Used by memory_cycle and its load alignment helper.
package memory_cycle_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [31:0] aluResult;
    logic [31:0] pcPlus4;
    logic [31:0] auLuResult;
    logic [31:0] readData;
    logic [4:0]  rd;
    logic [1:0]  resultSrc;
    logic        regWrite;
    logic        luau;
  } mw_t;

endpackage

// File: rtl/memory_cycle_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational; a is the already-adjusted byte offset.
module memory_cycle_load_align
  import memory_cycle_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  output logic [31:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = rdata[7:0];
    unique case (a)
      2'd0: byteLane = rdata[7:0];
      2'd1: byteLane = rdata[15:8];
      2'd2: byteLane = rdata[23:16];
      2'd3: byteLane = rdata[31:24];
    endcase
  end

  assign halfLane = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (funct3)
      F3_B:    data = {{24{byteLane[7]}}, byteLane};
      F3_BU:   data = {24'h0, byteLane};
      F3_H:    data = {{16{halfLane[15]}}, halfLane};
      F3_HU:   data = {16'h0, halfLane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// RV32I memory stage: lane alignment, dmem handshake, M/W register.
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] InstrM,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] AuLu_ResultM,
  input  logic        luauEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic        bus_err,
  output logic        misaligned,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] AuLu_ResultW,
  output logic [4:0]  RdW,
  output logic [1:0]  ResultSrcW,
  output logic        RegWriteW,
  output logic        luauW
);

  logic [2:0]  funct3;
  logic [1:0]  aRaw;
  logic [1:0]  a;
  logic        isH;
  logic        isW;
  logic        acc;
  logic        mis;
  logic        unusedInstr;

  assign funct3 = InstrM[14:12];
  assign aRaw   = ALUResultM[1:0];
  assign acc    = MemWriteM | (ResultSrcM == RESULTSRC_LOAD);
  assign isH    = (funct3 == F3_H) | (funct3 == F3_HU);
  assign isW    = (funct3 == F3_W);

  assign unusedInstr = ^{InstrM[31:15], InstrM[11:0]};

`ifdef MEM_MISALIGN_TRAP_EN
  assign a   = aRaw;
  assign mis = acc & ((isH & aRaw[0]) | (isW & (aRaw != 2'b00)));
`else
  // Sub-natural offset bits are simply dropped.
  assign a   = isW ? 2'b00 : (isH ? {aRaw[1], 1'b0} : aRaw);
  assign mis = 1'b0;
`endif

  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    dmem_wstrb = 4'b0000;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      unique case (1'b1)
        (funct3 == F3_B): begin
          dmem_wstrb = 4'b0001 << a;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        (funct3 == F3_H): begin
          dmem_wstrb = a[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        (funct3 == F3_W): begin
          dmem_wstrb = 4'b1111;
          dmem_wdata = WriteDataM;
        end
        default: dmem_wstrb = 4'b0000;
      endcase
    end
  end

  state_t            state;
  state_t            stateNxt;
  logic [CNT_W-1:0]  cnt;
  logic              reqRaw;
  logic              timeoutAbort;
  logic              stallInt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= (state == IDLE) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: if (acc && !mis && !dmem_ready) stateNxt = WAIT;
      WAIT: if (dmem_ready || timeoutAbort) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    reqRaw       = 1'b0;
    timeoutAbort = 1'b0;
    unique case (state)
      IDLE: reqRaw = acc & ~mis;
      WAIT: begin
        reqRaw       = 1'b1;
        // A same-cycle ready beats the timeout.
        timeoutAbort = (TIMEOUT_CYCLES != 0) && !dmem_ready &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES));
      end
      default: reqRaw = 1'b0;
    endcase
  end

  assign stallInt = reqRaw & ~dmem_ready & ~timeoutAbort;
  assign dmem_req = reqRaw & rst;
  assign StallM   = stallInt & rst;

  logic [31:0] alignedData;

  memory_cycle_load_align loadAlign (
    .rdata  (dmem_rdata),
    .funct3 (funct3),
    .a      (a),
    .data   (alignedData)
  );

  mw_t mw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw         <= '0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      bus_err    <= timeoutAbort;
      misaligned <= mis & (state == IDLE);
      if (stallInt) begin
        mw.regWrite <= 1'b0;
      end else begin
        mw.aluResult  <= ALUResultM;
        mw.pcPlus4    <= PCPlus4M;
        mw.auLuResult <= AuLu_ResultM;
        mw.readData   <= alignedData;
        mw.rd         <= RdM;
        mw.resultSrc  <= ResultSrcM;
        mw.regWrite   <= RegWriteM & ~timeoutAbort & ~mis;
        mw.luau       <= luauEM;
      end
    end
  end

  assign ReadDataW    = mw.readData;
  assign ALUResultW   = mw.aluResult;
  assign PCPlus4W     = mw.pcPlus4;
  assign AuLu_ResultW = mw.auLuResult;
  assign RdW          = mw.rd;
  assign ResultSrcW   = mw.resultSrc;
  assign RegWriteW    = mw.regWrite;
  assign luauW        = mw.luau;

endmodule
